// File: rtl/stream_max_finder.sv
// Running-maximum tracker over fixed-length frames of unsigned words.
// Reports the frame maximum and its first index with a one-cycle done pulse.

module Comparator #(
  parameter int B = 5
) (
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  output logic         gt
);
  assign gt = (a > b);
endmodule

// state | meaning
// IDLE  | waiting for start, last result held on max_val/max_idx
// LOAD  | accepting frame words, tracking the running maximum
// DONE  | single cycle, done pulse, result final
module stream_max_finder #(
  parameter int B  = 5,
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [B-1:0]  in_data,
  output logic          in_ready,
  output logic [B-1:0]  max_val,
  output logic [IW-1:0] max_idx,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] count;
  logic          cmp_out;
  logic          accept;

  Comparator #(.B(B)) u_cmp (
    .a  (in_data),
    .b  (max_val),
    .gt (cmp_out)
  );

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      max_val  <= '0;
      max_idx  <= '0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= LOAD;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            // First word seeds the maximum; strict > keeps the earliest index on ties
            if (count == '0) begin
              max_val <= in_data;
              max_idx <= '0;
            end else if (cmp_out) begin
              max_val <= in_data;
              max_idx <= count;
            end
            if (count == LAST_IDX) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_max_finder.sv
// Scoreboard bench for stream_max_finder: stimulus pushes the expected frame
// result, a negedge monitor pops and compares whenever done is seen.

module tb_stream_max_finder;

  localparam int B  = 5;
  localparam int N  = 8;
  localparam int IW = 3;

  typedef struct packed {
    logic [B-1:0]  v;
    logic [IW-1:0] i;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [B-1:0]  in_data = '0;
  logic          in_ready;
  logic [B-1:0]  max_val;
  logic [IW-1:0] max_idx;
  logic          done;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int done_cnt = 0;
  exp_t q[$];

  stream_max_finder #(.B(B), .N(N), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      check("done_has_expect", q.size(), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_max_val", int'(max_val), int'(e.v));
        check("sb_max_idx", int'(max_idx), int'(e.i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [B-1:0] w [N], input int gap_after,
                           input int gap_len, input bit start_noise,
                           input bit valid_on_start, input int exp_lat,
                           input exp_t e);
    int cyc;
    int seen;
    int d0;
    q.push_back(e);
    d0 = done_cnt;
    start    = 1'b1;
    in_valid = valid_on_start;
    in_data  = 5'd31;
    tick();
    cyc   = 1;
    start = start_noise;
    check("busy_in_load", int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      check("in_ready_load", int'(in_ready), 1);
      tick();
      cyc++;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          check("in_ready_bubble", int'(in_ready), 1);
          tick();
          cyc++;
        end
      end
    end
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 4 && seen == 0; k++) begin
      if (done === 1'b1) seen = 1;
      else begin
        tick();
        cyc++;
      end
    end
    check("done_seen", seen, 1);
    check("done_latency", cyc, exp_lat);
    check("in_ready_done", int'(in_ready), 0);
    check("busy_done", int'(busy), 1);
    tick();
    start = 1'b0;
    check("busy_after", int'(busy), 0);
    check("done_low_after", int'(done), 0);
    tick();
    check("busy_idle", int'(busy), 0);
    check("done_pulses", done_cnt - d0, 1);
    check("hold_max_val", int'(max_val), int'(e.v));
    check("hold_max_idx", int'(max_idx), int'(e.i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [B-1:0] f [N];

    rst = 1'b1;
    repeat (2) tick();
    check("rst_max_val", int'(max_val), 0);
    check("rst_max_idx", int'(max_idx), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // 1: ascending stream
    f = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    run_frame(f, -1, 0, 1'b0, 1'b0, 9, '{v: 5'd7, i: 3'd7});

    // 2: mixed stream, max at index 4
    f = '{5'b01000, 5'b00111, 5'b11001, 5'b00110,
          5'b11111, 5'b01011, 5'b11011, 5'b00000};
    run_frame(f, -1, 0, 1'b0, 1'b0, 9, '{v: 5'd31, i: 3'd4});

    // 3: all ties; a 31 offered with start must not be accepted
    f = '{5'b01001, 5'b01001, 5'b01001, 5'b01001,
          5'b01001, 5'b01001, 5'b01001, 5'b01001};
    run_frame(f, -1, 0, 1'b0, 1'b1, 9, '{v: 5'd9, i: 3'd0});

    // 4: two bubbles after the fourth word
    f = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd30};
    run_frame(f, 3, 2, 1'b0, 1'b0, 11, '{v: 5'd31, i: 3'd0});

    // 5: reset after 4 accepts discards the frame
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 5'd20 + 5'(i);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_max_val", int'(max_val), 0);
    check("midrst_max_idx", int'(max_idx), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_busy", int'(busy), 0);
    tick();
    check("midrst_idle_busy", int'(busy), 0);
    f = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd6};
    run_frame(f, -1, 0, 1'b0, 1'b0, 9, '{v: 5'd6, i: 3'd7});

    // 6: start held high through LOAD and DONE is ignored
    f = '{5'd3, 5'd17, 5'd2, 5'd17, 5'd9, 5'd1, 5'd0, 5'd16};
    run_frame(f, -1, 0, 1'b1, 1'b0, 9, '{v: 5'd17, i: 3'd1});
    repeat (3) tick();
    check("final_busy", int'(busy), 0);
    check("pending_expect", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
